player_marker_display: RTL and testbench
========================================

# player_marker_display

Parametrised successor to the single-dot game display. It draws a square player marker over a flat background and moves it in four directions from a key bus. Position updates once per frame during vertical blanking, with edge clamping or wrap-around. The block sits between the VGA timing driver, which supplies `h_count`/`v_count`, and the RGB output pins.

## Interface

Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `CW`, 10: width of the counter and position buses.
- `SIZE`, 2: marker edge length in pixels (≥1, < V_ACTIVE).
- `STEP`, 1: pixels moved per frame per held key (≥1, ≤ SIZE-independent, < V_ACTIVE-SIZE).
- `FG`, 24'hFF0000: marker colour.
- `BG`, 24'hFFFFFF: background colour.

Ports:
- `clk` in 1: pixel clock. Single clock domain.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: level input; leaves IDLE.
- `keys` in 4: {up, down, left, right}; asynchronous, held-level.
- `h_count` in CW: current pixel column from the VGA driver.
- `v_count` in CW: current line from the VGA driver.
- `rgb` out 24: registered pixel colour.
- `x_pos` out CW: marker left column.
- `y_pos` out CW: marker top line.
- `running` out 1: high in RUN.

## Operation

- Derived constants:
  - XMAX = H_ACTIVE-SIZE.
  - YMAX = V_ACTIVE-SIZE.
  - XC = XMAX/2 and YC = YMAX/2 (integer divide).
- Reset values:
  - `rgb`=0.
  - `x_pos`=XC and `y_pos`=YC (defaults 319/239).
  - `running`=0.
  - State = IDLE.
  - Key synchroniser cleared.
- `keys` pass through a 2-flop synchroniser; only the synchronised copy is used.
- `frame_tick` = (h_count==0 && v_count==V_ACTIVE), i.e. the first cycle of vertical blanking.
- States:
  - IDLE: marker hidden; position held at XC/YC. `start`==1 moves the block to RUN on the next edge.
  - RUN: `start` ignored; the block stays in RUN until reset.
- Movement (RUN only, on `frame_tick` cycles only):
  - left-right axis: right alone adds STEP; left alone subtracts STEP; both or neither leaves x unchanged.
  - Y axis: same rule with down (+) and up (−).
  - Axes are independent, so diagonal moves are allowed.
  - Arithmetic uses CW+1 bits so no intermediate result overflows.
- Pixel colour, for the current h_count/v_count:
  - Outside the active area (h≥H_ACTIVE or v≥V_ACTIVE): 0.
  - Active area, RUN, and x_pos≤h<x_pos+SIZE and y_pos≤v<y_pos+SIZE: FG.
  - Any other active pixel: BG.

## Timing

- `rgb` lags `h_count`/`v_count` by exactly 1 cycle.
- Key-to-sample latency is 2 cycles. A key must be stable at least 2 cycles before `frame_tick` to be counted.
- `x_pos`/`y_pos` update on the edge ending the `frame_tick` cycle, so they never change within the active area. At most one move happens per frame.
- `running` rises 1 cycle after `start` is sampled high in IDLE.
- If `start` is high in the same cycle as `frame_tick`, there is no move in that frame.
- Reset asserted mid-frame forces all outputs to their reset values immediately. After reset release, no move occurs before the next `frame_tick`.

## Configuration

- `MARKER_WRAP_EN` defined — wrap-around mode:
  - x+STEP>XMAX gives x+STEP−(XMAX+1).
  - x<STEP gives x+(XMAX+1)−STEP.
  - Same rules on Y with YMAX.
- `MARKER_WRAP_EN` undefined (default) — clamp mode:
  - x+STEP>XMAX gives XMAX.
  - x<STEP gives 0.
  - Same rules on Y.

## Test plan

- Reset then release, `start`=0 for a full frame → `x_pos`=319, `y_pos`=239, `running`=0, every active pixel BG, every blanking pixel 0.
- Pulse `start`, hold right for 3 frames (STEP=1) → `x_pos`=322 after the third `frame_tick`. `rgb`=FG at (322..323, 239..240), observed 1 cycle after the matching counts.
- Hold left and right together for 2 frames → `x_pos` stays constant. Hold up for 240 frames (clamp build) → `y_pos` reaches 0 and stays 0.
- Wrap build, SIZE=2, `x_pos`=638, right held 1 frame → `x_pos`=0. Then left held 1 frame → `x_pos`=638.
- Toggle `keys` only during the active area, ≥3 cycles away from `frame_tick` → `x_pos`/`y_pos` never change while v<480.
- Assert `rst` mid-line during RUN → `rgb`=0, `running`=0 and position 319/239 before the next clock edge.

Source files
------------

// File: rtl/player_marker_display.sv
// player_marker_display
//   Draws a SIZE x SIZE marker in colour FG over a flat BG background. The
//   marker is moved by a 4-key bus once per frame, on the first cycle of
//   vertical blanking. The design has one clock domain.
//
//   Compile-time option:
//     MARKER_WRAP_EN  defined   : the marker wraps around at the screen edges
//                     undefined : the marker is clamped at the screen edges (default)
//
//   Ports:
//     clk      pixel clock
//     rst      asynchronous reset, active low
//     start    level input; moves the block from IDLE to RUN
//     keys     {up, down, left, right}; asynchronous held levels, synchronised here
//     h_count  current pixel column from the VGA timing driver
//     v_count  current line from the VGA timing driver
//     rgb      registered pixel colour, one cycle behind h_count/v_count
//     x_pos    left column of the marker
//     y_pos    top line of the marker
//     running  high while in RUN
module player_marker_display #(
   parameter int          H_ACTIVE = 640,
   parameter int          V_ACTIVE = 480,
   parameter int          CW       = 10,
   parameter int          SIZE     = 2,
   parameter int          STEP     = 1,
   parameter logic [23:0] FG       = 24'hFF0000,
   parameter logic [23:0] BG       = 24'hFFFFFF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [3:0]    keys,
   input  logic [CW-1:0] h_count,
   input  logic [CW-1:0] v_count,
   output logic [23:0]   rgb,
   output logic [CW-1:0] x_pos,
   output logic [CW-1:0] y_pos,
   output logic          running
);

   localparam logic [CW:0]   XMAX   = (CW+1)'(H_ACTIVE - SIZE);
   localparam logic [CW:0]   YMAX   = (CW+1)'(V_ACTIVE - SIZE);
   localparam logic [CW-1:0] XC     = CW'((H_ACTIVE - SIZE) / 2);
   localparam logic [CW-1:0] YC     = CW'((V_ACTIVE - SIZE) / 2);
   localparam logic [CW:0]   H_ACT  = (CW+1)'(H_ACTIVE);
   localparam logic [CW:0]   V_ACT  = (CW+1)'(V_ACTIVE);
   localparam logic [CW:0]   SIZE_W = (CW+1)'(SIZE);
   localparam logic [CW:0]   STEP_W = (CW+1)'(STEP);
   localparam logic [CW:0]   ONE_W  = {{CW{1'b0}}, 1'b1};

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] x_q, x_d;
   logic [CW-1:0] y_q, y_d;
   logic [23:0]   rgb_q, rgb_d;
   logic [3:0]    key_s1_q, key_s2_q;

   logic [CW:0]   h_e, v_e, x_e, y_e;
   logic          frame_tick;
   logic          active, in_marker;

   // One axis move. inc/dec together cancel. Arithmetic is done CW+1 bits wide,
   // so p+STEP never overflows before the compare against pmax.
   function automatic logic [CW-1:0] next_pos(input logic [CW-1:0] p,
                                              input logic          inc,
                                              input logic          dec,
                                              input logic [CW:0]   pmax);
      logic [CW:0] pe, sum, res;
      pe  = {1'b0, p};
      sum = pe + STEP_W;
      res = pe;
      if (inc && !dec) begin
`ifdef MARKER_WRAP_EN
         if (sum > pmax) res = sum - (pmax + ONE_W);
         else            res = sum;
`else
         if (sum > pmax) res = pmax;
         else            res = sum;
`endif
      end else if (dec && !inc) begin
`ifdef MARKER_WRAP_EN
         if (pe < STEP_W) res = pe + (pmax + ONE_W) - STEP_W;
         else             res = pe - STEP_W;
`else
         if (pe < STEP_W) res = '0;
         else             res = pe - STEP_W;
`endif
      end
      return res[CW-1:0];
   endfunction

   assign h_e = {1'b0, h_count};
   assign v_e = {1'b0, v_count};
   assign x_e = {1'b0, x_q};
   assign y_e = {1'b0, y_q};

   assign frame_tick = (h_count == '0) && (v_e == V_ACT);
   assign active     = (h_e < H_ACT) && (v_e < V_ACT);
   assign in_marker  = (h_e >= x_e) && (h_e < x_e + SIZE_W) &&
                       (v_e >= y_e) && (v_e < y_e + SIZE_W);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      rgb_d   = '0;
      case (state_q)
         S_IDLE: begin
            x_d = XC;
            y_d = YC;
            if (start) state_d = S_RUN;
         end
         S_RUN: begin
            // keys: [3]=up, [2]=down, [1]=left, [0]=right
            if (frame_tick) begin
               x_d = next_pos(x_q, key_s2_q[0], key_s2_q[1], XMAX);
               y_d = next_pos(y_q, key_s2_q[2], key_s2_q[3], YMAX);
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (active) begin
         if ((state_q == S_RUN) && in_marker) rgb_d = FG;
         else                                 rgb_d = BG;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         x_q      <= XC;
         y_q      <= YC;
         rgb_q    <= '0;
         key_s1_q <= '0;
         key_s2_q <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         rgb_q    <= rgb_d;
         key_s1_q <= keys;
         key_s2_q <= key_s1_q;
      end
   end

   assign rgb     = rgb_q;
   assign x_pos   = x_q;
   assign y_pos   = y_q;
   assign running = (state_q == S_RUN);

endmodule

// File: tb/tb_player_marker_display.sv
// tb_player_marker_display
//   Drives a reduced-size raster (16x12 visible inside 20x15 total) into the
//   marker block with directed and random key patterns. A reference model
//   pushes the expected outputs into a scoreboard queue on every clock edge,
//   and a monitor process pops and compares on the falling edge. A second
//   instance with default parameters is used for the default reset position.
module tb_player_marker_display;

   localparam int HA = 16, VA = 12, HT = 20, VT = 15;
   localparam int SZ = 2, ST = 1, CW = 10;
   localparam int FGC = 32'h00FF0000;
   localparam int BGC = 32'h00FFFFFF;
   localparam int XMAX = HA - SZ, YMAX = VA - SZ;
   localparam int XC = XMAX / 2, YC = YMAX / 2;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [3:0]    keys;
   logic [CW-1:0] h_count, v_count;
   logic [23:0]   rgb;
   logic [CW-1:0] x_pos, y_pos;
   logic          running;

   logic [3:0]    d_keys = '0;
   logic          d_start = 1'b0;
   logic [9:0]    d_h = '0, d_v = '0;
   logic [23:0]   d_rgb;
   logic [9:0]    d_x, d_y;
   logic          d_running;

   always #5 clk = ~clk;

   player_marker_display #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .CW(CW), .SIZE(SZ), .STEP(ST),
      .FG(24'hFF0000), .BG(24'hFFFFFF)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .keys(keys),
      .h_count(h_count), .v_count(v_count),
      .rgb(rgb), .x_pos(x_pos), .y_pos(y_pos), .running(running)
   );

   player_marker_display dut_def (
      .clk(clk), .rst(rst), .start(d_start), .keys(d_keys),
      .h_count(d_h), .v_count(d_v),
      .rgb(d_rgb), .x_pos(d_x), .y_pos(d_y), .running(d_running)
   );

   typedef struct {
      int rgb;
      int x;
      int y;
      int run;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   int         m_run, m_x, m_y;
   logic [3:0] k1, k2;
   int         hc, vc;
   logic [3:0] cur_k;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic int mv(input int p, input bit inc, input bit dec, input int pmax);
      int r;
      r = p;
      if (inc && !dec) begin
         r = p + ST;
`ifdef MARKER_WRAP_EN
         if (r > pmax) r = r - (pmax + 1);
`else
         if (r > pmax) r = pmax;
`endif
      end else if (dec && !inc) begin
`ifdef MARKER_WRAP_EN
         if (p < ST) r = p + (pmax + 1) - ST;
         else        r = p - ST;
`else
         if (p < ST) r = 0;
         else        r = p - ST;
`endif
      end
      return r;
   endfunction

   // Called at each rising edge: predicts what the outputs hold after the edge.
   task automatic model_edge();
      exp_t e;
      int   h, v;
      bit   act, inm;
      if (!rst) begin
         m_run = 0; m_x = XC; m_y = YC; k1 = '0; k2 = '0;
         e = '{0, XC, YC, 0};
      end else begin
         h   = int'(h_count);
         v   = int'(v_count);
         act = (h < HA) && (v < VA);
         inm = (m_run != 0) && h >= m_x && h < m_x + SZ && v >= m_y && v < m_y + SZ;
         e.rgb = !act ? 0 : (inm ? FGC : BGC);
         if (m_run != 0 && h == 0 && v == VA) begin
            m_x = mv(m_x, k2[0], k2[1], XMAX);
            m_y = mv(m_y, k2[2], k2[3], YMAX);
         end
         if (m_run == 0 && start) m_run = 1;
         k2 = k1;
         k1 = keys;
         e.x = m_x; e.y = m_y; e.run = m_run;
      end
      sb.push_back(e);
   endtask

   task automatic cycle(input logic [3:0] k, input logic s);
      @(posedge clk);
      model_edge();
      #1;
      if (hc == HT - 1) begin
         hc = 0;
         vc = (vc == VT - 1) ? 0 : vc + 1;
      end else begin
         hc = hc + 1;
      end
      h_count = hc[CW-1:0];
      v_count = vc[CW-1:0];
      keys    = k;
      start   = s;
   endtask

   task automatic run(input int n, input logic [3:0] k, input bit rnd);
      cur_k = k;
      for (int i = 0; i < n; i++) begin
         if (rnd && $urandom_range(0, 29) == 0) cur_k = 4'($urandom_range(0, 15));
         cycle(cur_k, 1'b0);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rgb", 32'(rgb), e.rgb);
            chk("x_pos", 32'(x_pos), e.x);
            chk("y_pos", 32'(y_pos), e.y);
            chk("running", 32'(running), e.run);
         end
      end
   end

   initial begin : stim
      localparam int FR = HT * VT;
      rst = 1'b0; start = 1'b0; keys = '0;
      hc = 0; vc = 0;
      h_count = '0; v_count = '0;
      cur_k = '0;
      m_run = 0; m_x = XC; m_y = YC; k1 = '0; k2 = '0;

      repeat (3) cycle(4'b0000, 1'b0);
      chk("def_rst_rgb", 32'(d_rgb), 0);
      chk("def_rst_x", 32'(d_x), 319);
      chk("def_rst_y", 32'(d_y), 239);
      chk("def_rst_running", 32'(d_running), 0);
      rst = 1'b1;
      run(3, 4'b0000, 1'b0);
      chk("def_idle_bg", 32'(d_rgb), BGC);

      // idle for a full frame with keys toggling: nothing may move or show
      run(FR, 4'b0000, 1'b1);
      cycle(4'b0000, 1'b1);
      cycle(4'b0000, 1'b0);
      run(3 * FR, 4'b0001, 1'b0);    // right
      run(2 * FR, 4'b0011, 1'b0);    // left + right cancel
      run(8 * FR, 4'b1000, 1'b0);    // up into the top edge
      run(12 * FR, 4'b0001, 1'b0);   // right into the right edge
      run(FR, 4'b0001, 1'b0);
      run(FR, 4'b0010, 1'b0);        // left
      run(20 * FR, 4'b0000, 1'b1);

      // reset asserted mid-line: outputs must return before the next edge
      while (!(vc == 3 && hc == 5)) cycle(cur_k, 1'b0);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("midrst_rgb", 32'(rgb), 0);
      chk("midrst_running", 32'(running), 0);
      chk("midrst_x", 32'(x_pos), XC);
      chk("midrst_y", 32'(y_pos), YC);
      repeat (3) cycle(4'b0101, 1'b0);
      rst = 1'b1;
      run(FR / 2, 4'b0101, 1'b0);

      // start coincides with frame_tick: no move in that frame
      while (!(hc == HT - 1 && vc == VA - 1)) cycle(4'b0001, 1'b0);
      cycle(4'b0001, 1'b1);
      run(FR, 4'b0001, 1'b0);
      run(10 * FR, 4'b0000, 1'b1);

      @(negedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
